// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller. Generates the 16x oversample
// tick, synchronises the serial line, samples start/data/parity/stop at bit
// centres and hands each byte plus error flags to a valid/ready consumer.
module uart_rx_ctrl #(
   parameter int unsigned DIV        = 27,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rx_en,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       p_error,
   output logic       stop_error,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned   DW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]    sync_q, sync_d;
   logic          rxs;
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic          tick;

   state_t        state_q, state_d;
   logic [3:0]    tc_q, tc_d;
   logic [2:0]    bi_q, bi_d;
   logic [7:0]    shift_q, shift_d;
   logic          perr_q, perr_d;
   logic          serr;
   logic          deliver;

   logic [7:0]    rd_data_q, rd_data_d;
   logic          rd_valid_q, rd_valid_d;
   logic          p_error_q, p_error_d;
   logic          stop_error_q, stop_error_d;
   logic          overrun_q, overrun_d;
   logic          handshake, load, drop;

   assign rxs  = sync_q[1];
   assign tick = (div_cnt_q == DIV_LAST);

   // Two-flop synchroniser (idle-high reset) and free-running tick divider
   always_comb begin
      sync_d    = {sync_q[0], rx};
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
   end

   // Frame sequencer: next state, tick/bit counters, shift register, parity
   always_comb begin
      state_d = state_q;
      tc_d    = tc_q;
      bi_d    = bi_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      serr    = 1'b0;
      deliver = 1'b0;
      if (!rx_en) begin
         state_d = S_IDLE;
         tc_d    = '0;
         bi_d    = '0;
      end else if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (!rxs) begin
                  state_d = S_START;
                  tc_d    = '0;
                  bi_d    = '0;
               end
            end
            S_START: begin
               if (tc_q == 4'd7) begin
                  // mid start bit: a high line here means a glitch, not a frame
                  state_d = rxs ? S_IDLE : S_DATA;
                  tc_d    = '0;
                  bi_d    = '0;
               end else begin
                  tc_d = tc_q + 4'd1;
               end
            end
            S_DATA: begin
               tc_d = tc_q + 4'd1;
               if (tc_q == 4'd15) begin
                  shift_d[bi_q] = rxs;
                  if (bi_q == 3'd7) begin
                     state_d = PARITY_EN ? S_PARITY : S_STOP;
                     tc_d    = '0;
                     bi_d    = '0;
                  end else begin
                     bi_d = bi_q + 3'd1;
                  end
               end
            end
            S_PARITY: begin
               tc_d = tc_q + 4'd1;
               if (tc_q == 4'd15) begin
                  perr_d  = (^shift_q) ^ rxs ^ PARITY_ODD;
                  state_d = S_STOP;
                  tc_d    = '0;
                  bi_d    = '0;
               end
            end
            S_STOP: begin
               tc_d = tc_q + 4'd1;
               if (tc_q == 4'd15) begin
                  // return at mid stop bit so a short stop can still resync
                  serr    = ~rxs;
                  deliver = 1'b1;
                  state_d = S_IDLE;
                  tc_d    = '0;
                  bi_d    = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
               tc_d    = '0;
               bi_d    = '0;
            end
         endcase
      end
   end

   assign handshake = rd_valid_q & rd_ready;
   assign load      = deliver & (~rd_valid_q | rd_ready);
   assign drop      = deliver & ~load;

   // Output buffer: a new byte wins over a same-cycle handshake; a blocked one sets overrun
   always_comb begin
      rd_data_d    = rd_data_q;
      p_error_d    = p_error_q;
      stop_error_d = stop_error_q;
      rd_valid_d   = load | (rd_valid_q & ~handshake);
      overrun_d    = drop | (overrun_q & ~handshake);
      if (load) begin
         rd_data_d    = shift_q;
         p_error_d    = PARITY_EN ? perr_q : 1'b0;
         stop_error_d = serr;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= 2'b11;
         div_cnt_q    <= '0;
         state_q      <= S_IDLE;
         tc_q         <= '0;
         bi_q         <= '0;
         shift_q      <= '0;
         perr_q       <= 1'b0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         p_error_q    <= 1'b0;
         stop_error_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         div_cnt_q    <= div_cnt_d;
         state_q      <= state_d;
         tc_q         <= tc_d;
         bi_q         <= bi_d;
         shift_q      <= shift_d;
         perr_q       <= perr_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         p_error_q    <= p_error_d;
         stop_error_q <= stop_error_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign p_error    = p_error_q;
   assign stop_error = stop_error_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule
